mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32: address width of requester and memory ports.
REQ-002 Parameter DW, 32: data width of requester and memory ports.
REQ-003 Parameter TIMEOUT_CYC, 255: watchdog limit, in cycles, for an unacknowledged memory access.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 m0_req / m1_req  in  1  access request; m0 = CPU, m1 = debug/loader port.
REQ-007 m0_we / m1_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-008 m0_addr / m1_addr  in  AW  byte address; sampled at grant.
REQ-009 m0_wdata / m1_wdata  in  DW  write data; sampled at grant.
REQ-010 m0_rdy / m1_rdy  out  1  one-cycle completion pulse to the owning requester.
REQ-011 rdata  out  DW  registered read data, shared by both requesters.
REQ-012 grant  out  2  one-hot owner (bit0 = m0, bit1 = m1); 2'b00 when IDLE.
REQ-013 err  out  1  one-cycle pulse coincident with rdy when the access timed out.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  AW  memory address.
REQ-017 mem_wdata  out  DW  memory write data.
REQ-018 mem_rdata  in  DW  memory read data; valid when mem_ack = 1.
REQ-019 mem_ack  in  1  memory completion; any latency of 1 or more cycles.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS, RESP; all outputs registered.
REQ-021 In IDLE, if any req is high, the arbiter SHALL grant and move to ACCESS on the next edge.
- Single requester: that requester wins.
- Both requesters: the one not granted last wins (round-robin).
- last_gnt register resets to m1, so m0 wins the first tie.
REQ-022 At grant, the arbiter SHALL latch the winner's we/addr/wdata, drive them on mem_we/mem_addr/mem_wdata, and set mem_en = 1 and grant.
- These stay stable for the whole ACCESS state.
REQ-023 In ACCESS, mem_ack = 1 SHALL trigger, on that edge:
- mem_en and mem_we cleared;
- rdata loaded with mem_rdata on reads (held on writes);
- move to RESP.
REQ-024 In RESP, the owner's rdy SHALL be 1 for exactly one cycle; next state IDLE; grant cleared on leaving RESP.
REQ-025 Latency: req high in IDLE cycle 0, mem_ack in cycle 1 gives rdy in cycle 2. Each extra wait cycle adds 1.
REQ-026 Requests present during ACCESS or RESP SHALL be ignored.
- A requester must drop req by the edge ending its RESP cycle, or it is granted again.
REQ-027 Dropping req mid-ACCESS SHALL NOT abort the transaction; rdy still pulses.
REQ-028 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-029 m0_rdy and m1_rdy SHALL never be high in the same cycle.
REQ-030 rdata SHALL hold its value until the next read completes.

Reset
REQ-031 While sys_rst_n = 0 the block SHALL be held in reset:
- state IDLE, last_gnt = m1;
- mem_en, mem_we, m0_rdy, m1_rdy and err = 0;
- grant = 2'b00;
- mem_addr, mem_wdata and rdata = 0;
- watchdog counter = 0.
REQ-032 Reset asserted mid-ACCESS SHALL drop mem_en immediately (asynchronously); no rdy is issued for the aborted access.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack. When it reaches TIMEOUT_CYC, the block drops mem_en, moves to RESP, pulses rdy and err together, and leaves rdata unchanged. mem_ack in the same cycle as the limit takes priority (normal completion, err = 0).
- Undefined: ACCESS waits indefinitely, err is tied 0, and no counter logic exists.

Verification
REQ-034 m0 read of 0x0000_0010; memory acks 1 cycle later with 0x1234_5678 -> m0_rdy in cycle 2, rdata = 0x1234_5678, grant = 01 during ACCESS/RESP.
REQ-035 m0 and m1 request in the same cycle, both held for 4 accesses -> grant order m0, m1, m0, m1; m0_rdy and m1_rdy never coincide.
REQ-036 m1 write of 0xA5A5_A5A5 to 0x100 with mem_ack delayed 5 cycles -> mem_en held 5 cycles with mem_we = 1, addr/wdata stable, m1_rdy 1 cycle later, rdata unchanged.
REQ-037 ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 8, mem_ack never asserted -> mem_en drops after 8 ACCESS cycles, rdy and err pulse together, FSM returns to IDLE. Macro undefined -> mem_en stays high.
REQ-038 sys_rst_n pulled low in the 2nd ACCESS cycle -> mem_en = 0 immediately, no rdy. After release, a tied request goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter for two requesters (m0 = CPU, m1 = debug)
//            sharing a single ack-handshaked memory port. Define
//            ARB_TIMEOUT_EN to build in the access watchdog.
// Revision : 1.0 - initial release
// ============================================================================

module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rdy,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rdy,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_RESP   = 2'd2;

    logic [1:0]    r_state,     w_state_nxt;
    logic          r_last_m1,   w_last_m1_nxt;
    logic [1:0]    r_grant,     w_grant_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_rdata,     w_rdata_nxt;
    logic          r_m0_rdy,    w_m0_rdy_nxt;
    logic          r_m1_rdy,    w_m1_rdy_nxt;
    logic          w_pick_m1;
    logic          w_timeout;

    // m1 wins when alone, or on a tie when m0 owned the previous access
    assign w_pick_m1 = m1_req && (!m0_req || !r_last_m1);

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Fires on the edge that would take the count to TIMEOUT_CYC; ack wins
    assign w_timeout = (r_state == c_S_ACCESS) && !mem_ack &&
                       (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == c_S_ACCESS) && !mem_ack)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign w_timeout            = 1'b0;
    assign err                  = 1'b0;
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= c_S_IDLE;
            r_last_m1   <= 1'b1;
            r_grant     <= 2'b00;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_m0_rdy    <= 1'b0;
            r_m1_rdy    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_m1   <= w_last_m1_nxt;
            r_grant     <= w_grant_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_m0_rdy    <= w_m0_rdy_nxt;
            r_m1_rdy    <= w_m1_rdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (m0_req || m1_req)     w_state_nxt = c_S_ACCESS;
            c_S_ACCESS: if (mem_ack || w_timeout) w_state_nxt = c_S_RESP;
            c_S_RESP:                             w_state_nxt = c_S_IDLE;
            default:                              w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_last_m1_nxt   = r_last_m1;
        w_grant_nxt     = r_grant;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_m0_rdy_nxt    = 1'b0;
        w_m1_rdy_nxt    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (m0_req || m1_req) begin
                    w_last_m1_nxt   = w_pick_m1;
                    w_grant_nxt     = w_pick_m1 ? 2'b10 : 2'b01;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_pick_m1 ? m1_we    : m0_we;
                    w_mem_addr_nxt  = w_pick_m1 ? m1_addr  : m0_addr;
                    w_mem_wdata_nxt = w_pick_m1 ? m1_wdata : m0_wdata;
                end
            end
            c_S_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_m0_rdy_nxt = r_grant[0];
                    w_m1_rdy_nxt = r_grant[1];
                    if (mem_ack && !r_mem_we)
                        w_rdata_nxt = mem_rdata;
                end
            end
            c_S_RESP: w_grant_nxt = 2'b00;
            default:  w_grant_nxt = 2'b00;
        endcase
    end

    assign m0_rdy    = r_m0_rdy;
    assign m1_rdy    = r_m1_rdy;
    assign rdata     = r_rdata;
    assign grant     = r_grant;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a transaction-level
//            model of arbitration order and memory contents.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;

    localparam int TB_TO = 8;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_rdy, m1_rdy, err, mem_en, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: arbitration history, memory image, expected read data
    bit          model_last_m1;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] exp_rdata;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdy(m0_rdy),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdy(m1_rdy),
        .rdata(rdata), .grant(grant), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        sys_rst_n = 0;
        tick();
        sys_rst_n = 1;
        model_last_m1 = 1;
        exp_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst_n = 0;
        m0_req = 1; m1_req = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        n_checks++;
        if ({grant, mem_en, mem_we, m0_rdy, m1_rdy, err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {grant, mem_en, mem_we, m0_rdy, m1_rdy, err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", mem_addr, mem_wdata, rdata);
        end
        idle_inputs();
        sys_rst_n = 1;
        model_last_m1 = 1;
        exp_rdata = 0;
        tick();
        n_checks++;
        if ({grant, mem_en, m0_rdy, m1_rdy} !== 5'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 00000", {grant, mem_en, m0_rdy, m1_rdy});
        end
    endtask

    task automatic test_basic_read();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010; m0_wdata = $urandom;
        tick();
        n_checks++;
        if ({grant, mem_en, mem_we, m0_rdy} !== 5'b01100 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL read_access: grant %b en %b we %b rdy %b addr %h expected 01 1 0 0 00000010", grant, mem_en, mem_we, m0_rdy, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h1234_5678; m0_req = 0;
        tick();
        model_mem[32'h10] = 32'h1234_5678;
        exp_rdata = 32'h1234_5678;
        model_last_m1 = 0;
        n_checks++;
        if ({grant, m0_rdy, m1_rdy, err, mem_en} !== 6'b011000) begin
            n_fail++; $display("FAIL read_resp: got %b expected 011000", {grant, m0_rdy, m1_rdy, err, mem_en});
        end
        n_checks++;
        if (rdata !== exp_rdata) begin
            n_fail++; $display("FAIL read_rdata: got %h expected %h", rdata, exp_rdata);
        end
        mem_ack = 0;
        tick();
        n_checks++;
        if ({grant, m0_rdy, mem_en} !== 4'b0 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL read_idle: grant %b rdy %b en %b rdata %h expected 00 0 0 %h", grant, m0_rdy, mem_en, rdata, exp_rdata);
        end
    endtask

    task automatic test_round_robin();
        bit exp_m1;
        logic [31:0] ea;
        apply_reset();
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h0000_0040; m1_addr = 32'h0000_0080;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_m1 = !model_last_m1;
            model_last_m1 = exp_m1;
            ea = exp_m1 ? m1_addr : m0_addr;
            n_checks++;
            if (grant !== (exp_m1 ? 2'b10 : 2'b01) || mem_addr !== ea) begin
                n_fail++; $display("FAIL rr_grant[%0d]: grant %b addr %h expected %b %h", k, grant, mem_addr, exp_m1 ? 2'b10 : 2'b01, ea);
            end
            mem_ack = 1; mem_rdata = mem_value(ea);
            tick();
            exp_rdata = mem_value(ea);
            n_checks++;
            if ({m0_rdy, m1_rdy} !== {!exp_m1, exp_m1} || rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rr_rdy[%0d]: rdy %b rdata %h expected %b %h", k, {m0_rdy, m1_rdy}, rdata, {!exp_m1, exp_m1}, exp_rdata);
            end
            mem_ack = 0;
            tick();
            n_checks++;
            if ({grant, m0_rdy, m1_rdy} !== 4'b0) begin
                n_fail++; $display("FAIL rr_idle[%0d]: got %b expected 0000", k, {grant, m0_rdy, m1_rdy});
            end
        end
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_write_wait();
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0100; m1_wdata = 32'hA5A5_A5A5;
        tick();
        model_last_m1 = 1;
        m1_req = 0;
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if ({mem_en, mem_we, grant, m0_rdy, m1_rdy} !== 6'b111000) begin
                n_fail++; $display("FAIL wr_ctrl[%0d]: got %b expected 111000", c, {mem_en, mem_we, grant, m0_rdy, m1_rdy});
            end
            n_checks++;
            if (mem_addr !== 32'h100 || mem_wdata !== 32'hA5A5_A5A5) begin
                n_fail++; $display("FAIL wr_data[%0d]: addr %h wdata %h expected 00000100 a5a5a5a5", c, mem_addr, mem_wdata);
            end
            m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom);
            if (c == 5) begin mem_ack = 1; mem_rdata = $urandom; end
            tick();
        end
        model_mem[32'h100] = 32'hA5A5_A5A5;
        n_checks++;
        if ({m0_rdy, m1_rdy, err, mem_en, mem_we} !== 5'b01000 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL wr_resp: got %b rdata %h expected 01000 %h", {m0_rdy, m1_rdy, err, mem_en, mem_we}, rdata, exp_rdata);
        end
        mem_ack = 0;
        tick();
        n_checks++;
        if ({grant, m1_rdy} !== 3'b0) begin
            n_fail++; $display("FAIL wr_idle: got %b expected 000", {grant, m1_rdy});
        end
    endtask

    task automatic test_reset_mid_access();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0020;
        tick();
        model_last_m1 = 0;
        tick();
        n_checks++;
        if (mem_en !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: mem_en %b expected 1", mem_en);
        end
        #1 sys_rst_n = 0;
        #1;
        n_checks++;
        if ({mem_en, grant, m0_rdy, m1_rdy} !== 5'b0 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_async: got %b rdata %h expected 00000 0", {mem_en, grant, m0_rdy, m1_rdy}, rdata);
        end
        tick();
        sys_rst_n = 1;
        model_last_m1 = 1;
        exp_rdata = 0;
        m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0030;
        tick();
        n_checks++;
        if ({grant, m0_rdy, m1_rdy} !== 4'b0100) begin
            n_fail++; $display("FAIL rst_tie: got %b expected 0100", {grant, m0_rdy, m1_rdy});
        end
        model_last_m1 = 0;
        mem_ack = 1; mem_rdata = mem_value(32'h20); m0_req = 0; m1_req = 0;
        tick();
        exp_rdata = mem_value(32'h20);
        n_checks++;
        if ({m0_rdy, m1_rdy} !== 2'b10 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rst_after: rdy %b rdata %h expected 10 %h", {m0_rdy, m1_rdy}, rdata, exp_rdata);
        end
        mem_ack = 0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        cyc = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0044;
        tick();
        model_last_m1 = 0;
        m0_req = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            if (mem_en !== 1'b1) break;
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== TB_TO) begin
            n_fail++; $display("FAIL to_len: got %0d access cycles expected %0d", cyc, TB_TO);
        end
        n_checks++;
        if ({m0_rdy, m1_rdy, err, mem_en} !== 4'b1010 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL to_resp: got %b rdata %h expected 1010 %h", {m0_rdy, m1_rdy, err, mem_en}, rdata, exp_rdata);
        end
        tick();
        n_checks++;
        if ({grant, m0_rdy, err} !== 4'b0) begin
            n_fail++; $display("FAIL to_idle: got %b expected 0000", {grant, m0_rdy, err});
        end
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0048;
        tick();
        model_last_m1 = 1;
        m1_req = 0;
        repeat (TB_TO - 1) tick();
        mem_ack = 1; mem_rdata = mem_value(32'h48);
        tick();
        exp_rdata = mem_value(32'h48);
        n_checks++;
        if ({m0_rdy, m1_rdy, err} !== 3'b010 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL to_ack_limit: got %b rdata %h expected 010 %h", {m0_rdy, m1_rdy, err}, rdata, exp_rdata);
        end
        mem_ack = 0;
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            if (mem_en === 1'b1 && {m0_rdy, m1_rdy, err} === 3'b0) cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== 20) begin
            n_fail++; $display("FAIL no_to_hold: got %0d cycles with mem_en expected 20", cyc);
        end
        mem_ack = 1; mem_rdata = mem_value(32'h44);
        tick();
        exp_rdata = mem_value(32'h44);
        n_checks++;
        if ({m0_rdy, m1_rdy, err, mem_en} !== 4'b1000 || rdata !== exp_rdata) begin
            n_fail++; $display("FAIL no_to_resp: got %b rdata %h expected 1000 %h", {m0_rdy, m1_rdy, err, mem_en}, rdata, exp_rdata);
        end
        mem_ack = 0;
        tick();
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          pat;
            int          waits;
            bit          exp_m1;
            bit          hold;
            logic        ew;
            logic [31:0] ea, ed;
            pat = $urandom_range(0, 2);
            m0_req = (pat != 1); m1_req = (pat != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_addr = $urandom_range(0, 31) << 2; m1_addr = $urandom_range(0, 31) << 2;
            m0_wdata = $urandom; m1_wdata = $urandom;
            mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
            exp_m1 = (pat == 2) ? !model_last_m1 : (pat == 1);
            model_last_m1 = exp_m1;
            ew = exp_m1 ? m1_we    : m0_we;
            ea = exp_m1 ? m1_addr  : m0_addr;
            ed = exp_m1 ? m1_wdata : m0_wdata;
            tick();
            mem_ack = 0;
            hold = 1'($urandom);
            waits = $urandom_range(0, 3);
            for (int c = 0; c <= waits; c++) begin
                n_checks++;
                if ({grant, mem_en, mem_we, m0_rdy, m1_rdy} !== {(exp_m1 ? 2'b10 : 2'b01), 1'b1, ew, 2'b00}) begin
                    n_fail++; $display("FAIL rnd_ctrl[%0d.%0d]: got %b expected %b", t, c, {grant, mem_en, mem_we, m0_rdy, m1_rdy}, {(exp_m1 ? 2'b10 : 2'b01), 1'b1, ew, 2'b00});
                end
                n_checks++;
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    n_fail++; $display("FAIL rnd_data[%0d.%0d]: addr %h wdata %h expected %h %h", t, c, mem_addr, mem_wdata, ea, ed);
                end
                m0_req = m0_req && hold; m1_req = m1_req && hold;
                m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
                if (c == waits) begin
                    mem_ack = 1;
                    mem_rdata = ew ? $urandom : mem_value(ea);
                end
                tick();
            end
            if (!ew) exp_rdata = mem_value(ea);
            else model_mem[ea] = ed;
            n_checks++;
            if ({m0_rdy, m1_rdy, err, mem_en, mem_we} !== {!exp_m1, exp_m1, 3'b000} || rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: got %b rdata %h expected %b %h", t, {m0_rdy, m1_rdy, err, mem_en, mem_we}, rdata, {!exp_m1, exp_m1, 3'b000}, exp_rdata);
            end
            m0_req = 0; m1_req = 0;
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            tick();
            n_checks++;
            if ({grant, mem_en, m0_rdy, m1_rdy, err} !== 6'b0 || rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rnd_idle[%0d]: got %b rdata %h expected 000000 %h", t, {grant, mem_en, m0_rdy, m1_rdy, err}, rdata, exp_rdata);
            end
            mem_ack = 0;
        end
    endtask

    initial begin
        idle_inputs();
        sys_rst_n = 0;
        model_last_m1 = 1;
        exp_rdata = 0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write_wait();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
